// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the program counter and the F/D pipeline register, with MIPS delayed-branch semantics.
// Optional redirect counter output enabled by defining FETCH_REDIRECT_COUNT_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   input  logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
`ifdef FETCH_REDIRECT_COUNT_EN
   output logic [31:0] redirect_cnt,
`endif
   output logic        fetch_fault
);

   // Upper fetch bound held in 33 bits so a high IM_BASE cannot wrap it.
   localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

   logic [31:0] pc_next;
   logic        fetch_ok;
   logic [31:0] instr_fetched;

   always_comb begin
      fetch_ok = (pc_f[1:0] == 2'b00) && (pc_f >= IM_BASE) && ({1'b0, pc_f} < IM_LIMIT);
      instr_fetched = fetch_ok ? instr_f : 32'h0;
   end

   always_comb begin
      pc_next = pc_f;
      if (!stall) begin
         if (npc_sel) pc_next = npc_target;
         else         pc_next = pc_f + 32'd4;
      end
   end

   // F -> D boundary; the slot instruction fetched in a redirect cycle is always kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f        <= RESET_PC;
         instr_d     <= 32'h0;
         pc_d        <= RESET_PC;
         pc8_d       <= RESET_PC + 32'd8;
         fetch_fault <= 1'b0;
      end else if (!stall) begin
         pc_f    <= pc_next;
         instr_d <= instr_fetched;
         pc_d    <= pc_f;
         pc8_d   <= pc_f + 32'd8;
         if (!fetch_ok) fetch_fault <= 1'b1;
      end
   end

`ifdef FETCH_REDIRECT_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)                  redirect_cnt <= 32'h0;
      else if (!stall && npc_sel) redirect_cnt <= redirect_cnt + 32'd1;
   end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage owner of the program counter and the F/D pipeline register in the P6 five-stage MIPS core.
- Consumes the redirect pair (npc_sel, npc_target) produced by the D-stage next-PC logic, and the stall from the hazard unit.
- Drives the instruction-memory address and presents fetched instruction, PC and PC+8 to D.
- Implements MIPS delayed-branch semantics: the instruction after a branch or jump always reaches D.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest valid fetch address.
- IM_WORDS, 4096, number of instruction-memory words; valid fetch range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC and F/D.
- npc_sel  in  1  redirect request from D-stage next-PC logic.
- npc_target  in  32  redirect target address.
- instr_f  in  32  instruction-memory read data for pc_f (combinational).
- pc_f  out  32  current fetch address, driven to instruction memory.
- instr_d  out  32  F/D-registered instruction.
- pc_d  out  32  F/D-registered PC.
- pc8_d  out  32  pc_d + 8, the link value.
- fetch_fault  out  1  sticky flag for an out-of-range or misaligned fetch.

Behaviour:
- Reset (synchronous, on the clk edge with reset=1): pc_f=RESET_PC, instr_d=0 (nop), pc_d=RESET_PC, pc8_d=RESET_PC+8, fetch_fault=0. Reset overrides stall and npc_sel in the same cycle.
- Next-PC selection at each non-reset edge:
  - stall=1: PC and F/D hold their values. npc_sel is ignored, because D-stage operands are not valid during a stall.
  - stall=0, npc_sel=1: pc_f <= npc_target.
  - stall=0, npc_sel=0: pc_f <= pc_f + 4. Arithmetic is 32-bit and wraps modulo 2^32 with no special case.
- F/D update at each non-reset edge with stall=0: instr_d <= fetched word, pc_d <= pc_f, pc8_d <= pc_f + 8.
  - The slot instruction fetched in the redirect cycle is always captured; there is no flush. This provides the delay slot.
  - One-cycle latency from pc_f to the D outputs.
- Fetch validity:
  - A fetch is invalid if pc_f[1:0] != 0, pc_f < IM_BASE, or pc_f >= IM_BASE + 4*IM_WORDS.
  - The upper bound is computed in 33 bits so it does not overflow.
  - On an invalid fetch: the captured instruction is 32'h0 instead of instr_f, pc_d still records pc_f, and fetch_fault is set on the capturing edge.
  - fetch_fault stays set until reset.
  - Invalid-fetch detection happens only on non-stalled edges.
- Redirect targets are not validated here. A bad target surfaces as a fault on its fetch cycle.
- Simultaneous stall release and npc_sel=1: the redirect is taken on that edge.

Optional Feature:
- Macro: FETCH_REDIRECT_COUNT_EN.
- Defined: adds output port redirect_cnt (out, 32 bits).
  - Reset value is 0.
  - Increments by 1 on every edge where stall=0 and npc_sel=1; wraps at 2^32.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 unstalled cycles with npc_sel=0 -> pc_f sequence 0x3000, 0x3004, 0x3008, 0x300C; pc_d lags by one cycle; pc8_d = pc_d + 8.
- At pc_f=0x3008, npc_sel=1 with npc_target=0x3040 -> next edge pc_f=0x3040, pc_d=0x3008 (delay slot kept). The following edge pc_d=0x3040. With the macro defined, redirect_cnt=1.
- stall=1 for 2 cycles with npc_sel=1, npc_target=0x3100 -> pc_f, instr_d and pc_d unchanged. The redirect is not taken while stalled; with the macro defined, redirect_cnt does not change.
- npc_target=0x3002 -> the next fetch at pc_f=0x3002 gives instr_d=0 and fetch_fault=1. The flag stays set through later valid fetches.
- npc_target = IM_BASE + 4*IM_WORDS (0x7000 with defaults) -> out-of-range fault: instr_d=0, fetch_fault=1. Then reset -> pc_f=0x3000, fetch_fault=0.
- reset=1 asserted in the same cycle as npc_sel=1 and stall=1 -> pc_f=0x3000, instr_d=0, pc_d=0x3000, pc8_d=0x3008.
